ctrl: RTL and testbench

CTRL -- requirements
Module: ctrl

---
 rtl/ctrl.sv | 108 ++++++++++
 tb/tb_ctrl.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/ctrl.sv
// Main control decoder: turns the instruction opcode into datapath control
// strobes, registered so that every output follows op by exactly one cycle.
module ctrl #(
  parameter logic [5:0] R_TYPE = 6'b000000,
  parameter logic [5:0] LW     = 6'b100011,
  parameter logic [5:0] SW     = 6'b101011,
  parameter logic [5:0] BEQ    = 6'b000100,
  parameter logic [5:0] J      = 6'b000010
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] op,
  output logic       regWrite,
  output logic       memtoReg,
  output logic       regDst,
  output logic [1:0] aluOp,
  output logic       aluSrc,
  output logic       branch,
  output logic       jump,
  output logic       memWrite,
  output logic       illegal
);

  logic       reg_write_d, reg_write_q;
  logic       memto_reg_d, memto_reg_q;
  logic       reg_dst_d,   reg_dst_q;
  logic [1:0] alu_op_d,    alu_op_q;
  logic       alu_src_d,   alu_src_q;
  logic       branch_d,    branch_q;
  logic       jump_d,      jump_q;
  logic       mem_write_d, mem_write_q;
  logic       illegal_d,   illegal_q;

  // Every field defaults to 0 so unused controls are never X and an
  // unrecognised opcode decodes to a no-op with only illegal raised.
  always_comb begin
    reg_write_d = 1'b0;
    memto_reg_d = 1'b0;
    reg_dst_d   = 1'b0;
    alu_op_d    = 2'b00;
    alu_src_d   = 1'b0;
    branch_d    = 1'b0;
    jump_d      = 1'b0;
    mem_write_d = 1'b0;
    illegal_d   = 1'b0;
    case (op)
      R_TYPE: begin
        reg_write_d = 1'b1;
        reg_dst_d   = 1'b1;
        alu_op_d    = 2'b10;
      end
      LW: begin
        reg_write_d = 1'b1;
        memto_reg_d = 1'b1;
        alu_src_d   = 1'b1;
      end
      SW: begin
        alu_src_d   = 1'b1;
        mem_write_d = 1'b1;
      end
      BEQ: begin
        branch_d = 1'b1;
        alu_op_d = 2'b01;
      end
      J: begin
        jump_d = 1'b1;
      end
      default: begin
        illegal_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_write_q <= 1'b0;
      memto_reg_q <= 1'b0;
      reg_dst_q   <= 1'b0;
      alu_op_q    <= 2'b00;
      alu_src_q   <= 1'b0;
      branch_q    <= 1'b0;
      jump_q      <= 1'b0;
      mem_write_q <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      reg_write_q <= reg_write_d;
      memto_reg_q <= memto_reg_d;
      reg_dst_q   <= reg_dst_d;
      alu_op_q    <= alu_op_d;
      alu_src_q   <= alu_src_d;
      branch_q    <= branch_d;
      jump_q      <= jump_d;
      mem_write_q <= mem_write_d;
      illegal_q   <= illegal_d;
    end
  end

  assign regWrite = reg_write_q;
  assign memtoReg = memto_reg_q;
  assign regDst   = reg_dst_q;
  assign aluOp    = alu_op_q;
  assign aluSrc   = alu_src_q;
  assign branch   = branch_q;
  assign jump     = jump_q;
  assign memWrite = mem_write_q;
  assign illegal  = illegal_q;

endmodule

// File: tb/tb_ctrl.sv
// Randomised and directed bench for the ctrl decoder, checked against a
// table-driven model of the opcode-to-control mapping.
module tb_ctrl;

  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_J   = 6'b000010;

  logic       clk;
  logic       rst_n;
  logic [5:0] op;
  logic       regWrite, memtoReg, regDst, aluSrc, branch, jump, memWrite, illegal;
  logic [1:0] aluOp;

  int n_cmp = 0;
  int n_bad = 0;

  ctrl dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .op       (op),
    .regWrite (regWrite),
    .memtoReg (memtoReg),
    .regDst   (regDst),
    .aluOp    (aluOp),
    .aluSrc   (aluSrc),
    .branch   (branch),
    .jump     (jump),
    .memWrite (memWrite),
    .illegal  (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed as regWrite,memtoReg,regDst,aluSrc,branch,jump,memWrite,aluOp,illegal.
  function automatic logic [9:0] observed();
    return {regWrite, memtoReg, regDst, aluSrc, branch, jump, memWrite, aluOp, illegal};
  endfunction

  // Reference decode written straight from the opcode table rows.
  function automatic logic [9:0] model_row(input logic [5:0] o);
    logic [5:0]  ops  [5] = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_J};
    logic [9:0]  rows [5] = '{10'b1_0_1_0_0_0_0_10_0,
                              10'b1_1_0_1_0_0_0_00_0,
                              10'b0_0_0_1_0_0_1_00_0,
                              10'b0_0_0_0_1_0_0_01_0,
                              10'b0_0_0_0_0_1_0_00_0};
    for (int k = 0; k < 5; k++)
      if (ops[k] == o) return rows[k];
    return 10'b0_0_0_0_0_0_0_00_1;
  endfunction

  task automatic check_eq(input string tag, input logic [9:0] got, input logic [9:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic check_excl(input string tag);
    logic [9:0] o;
    o = observed();
    check_eq({tag, "_excl"},
             {8'd0, ($countones({branch, jump, memWrite}) <= 1), !(regWrite && memWrite)},
             10'b11);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step_op(input string tag, input logic [5:0] o);
    op = o;
    tick();
    check_eq(tag, observed(), model_row(o));
    check_excl(tag);
    $display("%s op=%b out=%b", tag, o, observed());
  endtask

  initial begin
    logic [5:0] seq [5] = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_J};
    logic [5:0] perm [64];
    rst_n = 1'b1;
    op    = OP_LW;
    tick();
    tick();

    // Asynchronous reset with R-type present: outputs clear before any edge.
    op    = OP_R;
    rst_n = 1'b0;
    #1;
    check_eq("async_rst", observed(), 10'd0);
    #2;
    rst_n = 1'b1;
    tick();
    check_eq("post_rst_r", observed(), 10'b1_0_1_0_0_0_0_10_0);

    for (int i = 0; i < 5; i++) step_op("seq", seq[i]);

    step_op("illegal_ff", 6'b111111);
    step_op("after_ill_lw", OP_LW);

    // SW with a reset pulse between edges.
    step_op("sw_pre", OP_SW);
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("sw_rst_mw", {9'd0, memWrite}, 10'd0);
    check_eq("sw_rst_all", observed(), 10'd0);
    rst_n = 1'b1;
    tick();
    check_eq("sw_post_mw", {9'd0, memWrite}, 10'd1);

    // Every opcode once, in shuffled order.
    for (int i = 0; i < 64; i++) perm[i] = 6'(i);
    for (int i = 63; i > 0; i--) begin
      int j;
      logic [5:0] t;
      j = $urandom_range(i, 0);
      t = perm[i]; perm[i] = perm[j]; perm[j] = t;
    end
    for (int i = 0; i < 64; i++) step_op("all64", perm[i]);

    // Random stream biased toward legal opcodes, with occasional reset pulses.
    for (int i = 0; i < 200; i++) begin
      logic [5:0] o;
      if ($urandom_range(1, 0) == 1) o = seq[$urandom_range(4, 0)];
      else o = 6'($urandom);
      step_op("rand", o);
      if ($urandom_range(15, 0) == 0) begin
        rst_n = 1'b0;
        #1;
        check_eq("rand_rst", observed(), 10'd0);
        rst_n = 1'b1;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
